core_inst_gen: RTL and testbench

- Instruction sequencer that drives the 34-bit core instruction word, replacing the hand-written testbench instruction stream.
- Runs one full convolution pass: weight load, activation load, execute and output-FIFO drain to pmem, repeated for each kernel index (kij).
- Finishes with an accumulation pass through the SFP.
- Sits beside the core and consumes its ofifo_valid as a handshake.

---
 rtl/core_inst_pkg.sv | 54 +++++
 rtl/core_inst_gen_if.sv | 35 +++
 rtl/core_inst_gen_field_pack.sv | 25 ++
 rtl/core_inst_gen.sv | 172 +++++++++++++++++
 tb/tb_core_inst_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/core_inst_pkg.sv
// rtl/core_inst_pkg.sv - instruction word bit map, idle word, field struct and sequencer states
package core_inst_pkg;
  localparam int INST_W        = 34;
  localparam int FIELD_ADDR_W  = 11;

  localparam int ACC_BIT       = 33;
  localparam int CEN_PMEM_BIT  = 32;
  localparam int WEN_PMEM_BIT  = 31;
  localparam int PMEM_ADDR_LSB = 20;
  localparam int CEN_XMEM_BIT  = 19;
  localparam int WEN_XMEM_BIT  = 18;
  localparam int XMEM_ADDR_LSB = 7;
  localparam int OFIFO_RD_BIT  = 6;
  localparam int IFIFO_WR_BIT  = 5;
  localparam int IFIFO_RD_BIT  = 4;
  localparam int L0_RD_BIT     = 3;
  localparam int L0_WR_BIT     = 2;
  localparam int EXECUTE_BIT   = 1;
  localparam int LOAD_BIT      = 0;

  // Both SRAMs disabled and write-protected, nothing else active.
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WLD, ST_WPE, ST_ALD, ST_EXE, ST_DRN, ST_NEXT, ST_ACC, ST_DONE
  } state_t;

  typedef struct packed {
    logic                    acc;
    logic                    cen_pmem;
    logic                    wen_pmem;
    logic [FIELD_ADDR_W-1:0] pmem_addr;
    logic                    cen_xmem;
    logic                    wen_xmem;
    logic [FIELD_ADDR_W-1:0] xmem_addr;
    logic                    ofifo_rd;
    logic                    ififo_wr;
    logic                    ififo_rd;
    logic                    l0_rd;
    logic                    l0_wr;
    logic                    execute;
    logic                    load;
  } inst_fields_t;

  function automatic inst_fields_t idle_fields();
    inst_fields_t f;
    f          = '0;
    f.cen_pmem = 1'b1;
    f.wen_pmem = 1'b1;
    f.cen_xmem = 1'b1;
    f.wen_xmem = 1'b1;
    return f;
  endfunction
endpackage

// File: rtl/core_inst_gen_if.sv
// rtl/core_inst_gen_if.sv - sequencer control, status and instruction bus; stall_cnt under INST_GEN_PERF_EN
interface core_inst_gen_if #(
  parameter int cnt_w  = 8,
  parameter int addr_w = 11
);
  logic                              start;
  logic [cnt_w-1:0]                  n_kij;
  logic [cnt_w-1:0]                  n_act;
  logic [addr_w-1:0]                 w_base;
  logic [addr_w-1:0]                 a_base;
  logic [addr_w-1:0]                 o_base;
  logic                              ofifo_valid;
  logic [core_inst_pkg::INST_W-1:0]  inst;
  logic                              busy;
  logic                              done;
`ifdef INST_GEN_PERF_EN
  logic [31:0]                       stall_cnt;
`endif

  modport master (
    output start, n_kij, n_act, w_base, a_base, o_base, ofifo_valid,
    input  inst, busy, done
`ifdef INST_GEN_PERF_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, n_kij, n_act, w_base, a_base, o_base, ofifo_valid,
    output inst, busy, done
`ifdef INST_GEN_PERF_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/core_inst_gen_field_pack.sv
// rtl/core_inst_gen_field_pack.sv - packs instruction field values into the 34-bit core word
module inst_field_pack
  import core_inst_pkg::*;
(
  input  inst_fields_t      fields,
  output logic [INST_W-1:0] word
);
  always_comb begin
    word                                    = '0;
    word[ACC_BIT]                           = fields.acc;
    word[CEN_PMEM_BIT]                      = fields.cen_pmem;
    word[WEN_PMEM_BIT]                      = fields.wen_pmem;
    word[PMEM_ADDR_LSB +: FIELD_ADDR_W]     = fields.pmem_addr;
    word[CEN_XMEM_BIT]                      = fields.cen_xmem;
    word[WEN_XMEM_BIT]                      = fields.wen_xmem;
    word[XMEM_ADDR_LSB +: FIELD_ADDR_W]     = fields.xmem_addr;
    word[OFIFO_RD_BIT]                      = fields.ofifo_rd;
    word[IFIFO_WR_BIT]                      = fields.ififo_wr;
    word[IFIFO_RD_BIT]                      = fields.ififo_rd;
    word[L0_RD_BIT]                         = fields.l0_rd;
    word[L0_WR_BIT]                         = fields.l0_wr;
    word[EXECUTE_BIT]                       = fields.execute;
    word[LOAD_BIT]                          = fields.load;
  end
endmodule

// File: rtl/core_inst_gen.sv
// rtl/core_inst_gen.sv - convolution-pass instruction sequencer; INST_GEN_PERF_EN adds the stall_cnt counter
module core_inst_gen
  import core_inst_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 8
) (
  input  logic            clk,
  input  logic            reset,
  core_inst_gen_if.slave  bus
);
  localparam int CW = cnt_w + 1;

  state_t             state;
  inst_fields_t       fld;
  logic               busy_q, done_q;
  logic [CW-1:0]      cnt;
  logic [cnt_w-1:0]   k, kk, n_kij_q, n_act_q;
  logic [addr_w-1:0]  w_ptr, p_ptr, acc_addr, a_base_q, o_base_q;

  // Weights and psums are laid out contiguously, so running pointers replace k*row / k*n_act.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fld      <= idle_fields();
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      k        <= '0;
      kk       <= '0;
      n_kij_q  <= '0;
      n_act_q  <= '0;
      w_ptr    <= '0;
      p_ptr    <= '0;
      acc_addr <= '0;
      a_base_q <= '0;
      o_base_q <= '0;
    end else begin
      fld    <= idle_fields();
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) begin
          n_kij_q  <= bus.n_kij;
          n_act_q  <= bus.n_act;
          w_ptr    <= bus.w_base;
          a_base_q <= bus.a_base;
          o_base_q <= bus.o_base;
          p_ptr    <= '0;
          k        <= '0;
          cnt      <= '0;
          busy_q   <= 1'b1;
          state    <= ST_WLD;
        end
        ST_WLD: if (cnt < CW'(row)) begin
          fld.cen_xmem  <= 1'b0;
          fld.xmem_addr <= FIELD_ADDR_W'(w_ptr);
          fld.l0_wr     <= (cnt != '0);
          w_ptr         <= w_ptr + addr_w'(1);
          cnt           <= cnt + CW'(1);
        end else begin
          fld.l0_wr <= 1'b1;
          cnt       <= '0;
          state     <= ST_WPE;
        end
        ST_WPE: begin
          fld.l0_rd <= 1'b1;
          fld.load  <= 1'b1;
          if (cnt == CW'(row + col - 1)) begin
            cnt   <= '0;
            state <= ST_ALD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ALD: if (cnt < {1'b0, n_act_q}) begin
          fld.cen_xmem  <= 1'b0;
          fld.xmem_addr <= FIELD_ADDR_W'(a_base_q + addr_w'(cnt));
          fld.l0_wr     <= (cnt != '0);
          cnt           <= cnt + CW'(1);
        end else begin
          fld.l0_wr <= 1'b1;
          cnt       <= '0;
          state     <= ST_EXE;
        end
        ST_EXE: begin
          fld.l0_rd   <= 1'b1;
          fld.execute <= 1'b1;
          if (cnt + CW'(1) == {1'b0, n_act_q}) begin
            cnt   <= '0;
            state <= ST_DRN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DRN: if (bus.ofifo_valid) begin
          fld.ofifo_rd  <= 1'b1;
          fld.cen_pmem  <= 1'b0;
          fld.wen_pmem  <= 1'b0;
          fld.pmem_addr <= FIELD_ADDR_W'(p_ptr);
          p_ptr         <= p_ptr + addr_w'(1);
          if (cnt + CW'(1) == {1'b0, n_act_q}) begin
            cnt   <= '0;
            state <= ST_NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_NEXT: if ({1'b0, k} + CW'(1) < {1'b0, n_kij_q}) begin
          k     <= k + cnt_w'(1);
          state <= ST_WLD;
        end else begin
          cnt      <= '0;
          kk       <= '0;
          acc_addr <= '0;
          state    <= ST_ACC;
        end
        // cnt is the output index, kk the kij being summed into it.
        ST_ACC: if (kk < n_kij_q) begin
          fld.acc       <= 1'b1;
          fld.cen_pmem  <= 1'b0;
          fld.pmem_addr <= FIELD_ADDR_W'(acc_addr);
          acc_addr      <= acc_addr + addr_w'(n_act_q);
          kk            <= kk + cnt_w'(1);
        end else begin
          fld.acc       <= 1'b1;
          fld.cen_pmem  <= 1'b0;
          fld.wen_pmem  <= 1'b0;
          fld.pmem_addr <= FIELD_ADDR_W'(o_base_q + addr_w'(cnt));
          kk            <= '0;
          acc_addr      <= addr_w'(cnt) + addr_w'(1);
          if (cnt + CW'(1) == {1'b0, n_act_q}) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  inst_field_pack u_pack (
    .fields (fld),
    .word   (bus.inst)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef INST_GEN_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      stall_cnt <= '0;
    end else if (state == ST_DRN && !bus.ofifo_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_core_inst_gen.sv
// tb/tb_core_inst_gen.sv - table-driven bench comparing the full instruction stream per scenario
module tb_core_inst_gen;
  import core_inst_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_inst_gen_if #(.cnt_w(8), .addr_w(11)) bus_i ();

  core_inst_gen #(.row(8), .col(8), .addr_w(11), .cnt_w(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  typedef struct {
    int n_kij;
    int n_act;
    int w_base;
    int a_base;
    int o_base;
    bit vout;
    int stall_at;
    int stall_len;
    int extra_start;
    int abort_at;
    int exp_len;
    int exp_stall;
  } scen_t;

  scen_t        tbl[6];
  int           total = 0;
  int           bad   = 0;
  logic [33:0]  exp_q[$];
  bit           vp_q[$];
  logic [33:0]  idle_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [33:0] mk(input bit acc, input bit cp, input bit wp, input int pa,
                                     input bit cx, input int xa, input bit ord, input bit l0r,
                                     input bit l0w, input bit ex, input bit ld);
    logic [33:0] w;
    w = '0;
    w[ACC_BIT] = acc;
    w[CEN_PMEM_BIT] = cp;
    w[WEN_PMEM_BIT] = wp;
    w[30:20] = pa[10:0];
    w[CEN_XMEM_BIT] = cx;
    w[WEN_XMEM_BIT] = 1'b1;
    w[17:7] = xa[10:0];
    w[OFIFO_RD_BIT] = ord;
    w[L0_RD_BIT] = l0r;
    w[L0_WR_BIT] = l0w;
    w[EXECUTE_BIT] = ex;
    w[LOAD_BIT] = ld;
    return w;
  endfunction

  task automatic push(input logic [33:0] w, input bit v);
    exp_q.push_back(w);
    vp_q.push_back(v);
  endtask

  task automatic gen(input scen_t s);
    exp_q.delete();
    vp_q.delete();
    for (int k = 0; k < s.n_kij; k++) begin
      for (int r = 0; r < 8; r++) push(mk(0, 1, 1, 0, 0, s.w_base + k * 8 + r, 0, 0, r > 0, 0, 0), s.vout);
      push(mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0), s.vout);
      for (int c = 0; c < 16; c++) push(mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1), s.vout);
      for (int i = 0; i < s.n_act; i++) push(mk(0, 1, 1, 0, 0, s.a_base + i, 0, 0, i > 0, 0, 0), s.vout);
      push(mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0), s.vout);
      for (int i = 0; i < s.n_act; i++) push(mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0), s.vout);
      for (int i = 0; i < s.n_act; i++) begin
        if (k == 0 && i == s.stall_at)
          for (int j = 0; j < s.stall_len; j++) push(idle_w, 1'b0);
        push(mk(0, 0, 0, k * s.n_act + i, 1, 0, 1, 0, 0, 0, 0), 1'b1);
      end
      push(idle_w, s.vout);
    end
    for (int i = 0; i < s.n_act; i++) begin
      for (int k = 0; k < s.n_kij; k++) push(mk(1, 0, 1, k * s.n_act + i, 1, 0, 0, 0, 0, 0, 0), s.vout);
      push(mk(1, 0, 0, s.o_base + i, 1, 0, 0, 0, 0, 0, 0), s.vout);
    end
  endtask

  task automatic run(input int id, input scen_t s);
    int  seen;
    int  done_at;
    bit  aborted;
    gen(s);
    @(negedge clk);
    bus_i.n_kij       = 8'(s.n_kij);
    bus_i.n_act       = 8'(s.n_act);
    bus_i.w_base      = 11'(s.w_base);
    bus_i.a_base      = 11'(s.a_base);
    bus_i.o_base      = 11'(s.o_base);
    bus_i.ofifo_valid = s.vout;
    bus_i.start       = 1'b1;
    @(negedge clk);
    bus_i.start = 1'b0;
    check($sformatf("s%0d busy_on", id), 64'(bus_i.busy), 64'd1);
    bus_i.ofifo_valid = vp_q[0];
    seen    = 0;
    done_at = -1;
    aborted = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge clk);
      if (t == s.abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("s%0d abort_inst", id), 64'(bus_i.inst), 64'(idle_w));
        check($sformatf("s%0d abort_busy", id), 64'(bus_i.busy), 64'd0);
`ifdef INST_GEN_PERF_EN
        check($sformatf("s%0d abort_stall", id), 64'(bus_i.stall_cnt), 64'd0);
`endif
        @(negedge clk);
        reset   = 1'b1;
        aborted = 1'b1;
        break;
      end
      check($sformatf("s%0d inst[%0d]", id, t), 64'(bus_i.inst), 64'(exp_q[t]));
      if (bus_i.done) begin
        seen++;
        if (done_at < 0) done_at = t;
      end
      bus_i.start       = (t == s.extra_start);
      bus_i.ofifo_valid = (t + 1 < exp_q.size()) ? vp_q[t + 1] : 1'b1;
    end
    if (!aborted) begin
      check($sformatf("s%0d done_once", id), 64'(seen), 64'd1);
      check($sformatf("s%0d done_len", id), 64'(done_at + 1), 64'(s.exp_len));
      @(negedge clk);
      check($sformatf("s%0d end_inst", id), 64'(bus_i.inst), 64'(idle_w));
      check($sformatf("s%0d end_busy", id), 64'(bus_i.busy), 64'd0);
      check($sformatf("s%0d end_done", id), 64'(bus_i.done), 64'd0);
`ifdef INST_GEN_PERF_EN
      check($sformatf("s%0d stall_cnt", id), 64'(bus_i.stall_cnt), 64'(s.exp_stall));
`endif
    end
  endtask

  initial begin
    idle_w = 34'h1_800C_0000;
    //          nk na  w_base  a_base  o_base vout st_at st_len xstart abort len stall
    tbl[0] = '{1, 4, 'h010, 'h040, 'h100, 1'b1, -1, 0, -1, -1, 47, 0};
    tbl[1] = '{3, 2, 'h020, 'h050, 'h200, 1'b0, -1, 0, -1, -1, 107, 0};
    tbl[2] = '{2, 3, 'h030, 'h060, 'h300, 1'b1, 1, 5, -1, -1, 86, 5};
    tbl[3] = '{2, 1, 'h7FC, 'h7FF, 'h7FF, 1'b1, -1, 0, -1, -1, 63, 0};
    tbl[4] = '{1, 4, 'h010, 'h040, 'h100, 1'b1, -1, 0, 30, -1, 47, 0};
    tbl[5] = '{3, 2, 'h020, 'h050, 'h200, 1'b1, -1, 0, -1, 31, 0, 0};

    reset             = 1'b0;
    bus_i.start       = 1'b0;
    bus_i.ofifo_valid = 1'b0;
    bus_i.n_kij       = '0;
    bus_i.n_act       = '0;
    bus_i.w_base      = '0;
    bus_i.a_base      = '0;
    bus_i.o_base      = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_i.start = ~bus_i.start;
      check($sformatf("rst%0d inst", c), 64'(bus_i.inst), 64'(idle_w));
      check($sformatf("rst%0d busy", c), 64'(bus_i.busy), 64'd0);
      check($sformatf("rst%0d done", c), 64'(bus_i.done), 64'd0);
    end
    bus_i.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run(i, tbl[i]);
    run(6, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
